// File: rtl/mpram_apb_ctrl.sv
// mpram_apb_ctrl
// Single-outstanding command sequencer for the coefficient/config register
// file. A host command is accepted in IDLE, its address is decoded into one
// of five one-hot region enables, a SETUP->ACCESS transfer is run on the
// APB-style port, and exactly one response pulse is returned per command.
// Bad addresses and PREADY timeouts are reported as errors and counted in a
// saturating error counter.
module mpram_apb_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 32,
    parameter int TAPS       = 72,
    parameter int NUM_DENUM  = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,

    output logic                  resp_valid,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic [7:0]            err_count,

    output logic                  FRAC_DECI_EN,
    output logic                  IIR_EN,
    output logic                  CTRL_EN,
    output logic                  CIC_EN,
    output logic                  FIR_EN,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] DATA_ADDR,
    output logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA
);

    // Region boundaries. B is the first address past the coefficient space.
    localparam logic [31:0] B_BASE      = 32'(TAPS + 3 * NUM_DENUM);
    localparam logic [31:0] TAPS_END    = 32'(TAPS);
    localparam logic [31:0] CTRL_END    = B_BASE + 32'd7;
    localparam logic [31:0] FRAC_ST_END = B_BASE + 32'd9;
    localparam logic [31:0] IIR_ST_END  = B_BASE + 32'd15;
    localparam logic [31:0] CIC_ST_END  = B_BASE + 32'd17;
    localparam logic [31:0] FIR_ST_END  = B_BASE + 32'd19;

    // The wait counter only has to reach TIMEOUT-1 before the transfer is
    // abandoned, so it is sized for that value.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Region enable vector layout: {FIR, CIC, CTRL, IIR, FRAC_DECI}.
    localparam int EN_FRAC = 0;
    localparam int EN_IIR  = 1;
    localparam int EN_CTRL = 2;
    localparam int EN_CIC  = 3;
    localparam int EN_FIR  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                  state_q,      state_d;
    logic                    cmd_ready_q,  cmd_ready_d;
    logic [4:0]              en_q,         en_d;
    logic                    pwrite_q,     pwrite_d;
    logic                    penable_q,    penable_d;
    logic [ADDR_WIDTH-1:0]   addr_q,       addr_d;
    logic [DATA_WIDTH-1:0]   data_q,       data_d;
    logic [CNT_W-1:0]        count_q,      count_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q,   resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [7:0]              err_count_q,  err_count_d;

    logic [4:0]              decoded_en;

    // Maps an address onto its one-hot region enable; all-zero marks an
    // address outside the register map.
    function automatic logic [4:0] decode_region(input logic [ADDR_WIDTH-1:0] a);
        logic [31:0] av;
        logic [4:0]  en;
        av = 32'(a);
        en = 5'b00000;
        if (av < TAPS_END) begin
            en[EN_FRAC] = 1'b1;
        end else if (av < B_BASE) begin
            en[EN_IIR] = 1'b1;
        end else if (av == B_BASE) begin
            en[EN_CIC] = 1'b1;
        end else if (av < CTRL_END) begin
            en[EN_CTRL] = 1'b1;
        end else if (av < FRAC_ST_END) begin
            en[EN_FRAC] = 1'b1;
        end else if (av < IIR_ST_END) begin
            en[EN_IIR] = 1'b1;
        end else if (av < CIC_ST_END) begin
            en[EN_CIC] = 1'b1;
        end else if (av < FIR_ST_END) begin
            en[EN_FIR] = 1'b1;
        end
        return en;
    endfunction

    // Error counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Address decode of the command currently presented by the host.
    always_comb begin
        decoded_en = decode_region(cmd_addr);
    end

    // Next-state and next-output computation. All outputs are registered, so
    // each transition loads the values the next state must present.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        en_d         = en_q;
        pwrite_d     = pwrite_q;
        penable_d    = penable_q;
        addr_d       = addr_q;
        data_d       = data_q;
        count_d      = count_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        err_count_d  = err_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_ready_d = 1'b0;
                    if (decoded_en != 5'b00000) begin
                        state_d   = SETUP;
                        en_d      = decoded_en;
                        pwrite_d  = cmd_write;
                        penable_d = 1'b0;
                        addr_d    = cmd_addr;
                        data_d    = cmd_wdata;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                        err_count_d  = sat_inc(err_count_q);
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                count_d   = '0;
            end

            ACCESS: begin
                if (PREADY || (count_q == CNT_LAST)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = !PREADY;
                    resp_rdata_d = (PREADY && !pwrite_q) ? PRDATA : '0;
                    if (!PREADY) begin
                        err_count_d = sat_inc(err_count_q);
                    end
                    en_d      = '0;
                    pwrite_d  = 1'b0;
                    penable_d = 1'b0;
                    addr_d    = '0;
                    data_d    = '0;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end

            RESP: begin
                state_d      = IDLE;
                cmd_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = '0;
            end

            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    // FSM state and registered outputs; reset drops any in-flight command.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b1;
            en_q         <= '0;
            pwrite_q     <= 1'b0;
            penable_q    <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            count_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            en_q         <= en_d;
            pwrite_q     <= pwrite_d;
            penable_q    <= penable_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            count_q      <= count_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            err_count_q  <= err_count_d;
        end
    end

    // cmd_ready is held low while reset is asserted so no command can be
    // accepted in the same cycle the controller is being cleared.
    assign cmd_ready    = cmd_ready_q & ~rst;
    assign resp_valid   = resp_valid_q;
    assign resp_err     = resp_err_q;
    assign resp_rdata   = resp_rdata_q;
    assign err_count    = err_count_q;
    assign FRAC_DECI_EN = en_q[EN_FRAC];
    assign IIR_EN       = en_q[EN_IIR];
    assign CTRL_EN      = en_q[EN_CTRL];
    assign CIC_EN       = en_q[EN_CIC];
    assign FIR_EN       = en_q[EN_FIR];
    assign PWRITE       = pwrite_q;
    assign PENABLE      = penable_q;
    assign DATA_ADDR    = addr_q;
    assign DATA_IN      = data_q;

endmodule

// File: tb/tb_mpram_apb_ctrl.sv
// tb_mpram_apb_ctrl
// Directed bench for the register-file command sequencer. Each command pushes
// its expected response onto a scoreboard queue; the entry is popped when the
// DUT raises resp_valid. Bus signals are checked cycle by cycle against a
// reference address map written out independently of the design.
module tb_mpram_apb_ctrl;

    localparam int TIMEOUT = 15;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  err_count;
    logic        FRAC_DECI_EN;
    logic        IIR_EN;
    logic        CTRL_EN;
    logic        CIC_EN;
    logic        FIR_EN;
    logic        PWRITE;
    logic        PENABLE;
    logic [6:0]  DATA_ADDR;
    logic [31:0] DATA_IN;
    logic        PREADY;
    logic [31:0] PRDATA;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   errCnt     = 0;

    mpram_apb_ctrl #(
        .ADDR_WIDTH(7),
        .DATA_WIDTH(32),
        .TAPS(72),
        .NUM_DENUM(5),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .resp_valid(resp_valid),
        .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .err_count(err_count),
        .FRAC_DECI_EN(FRAC_DECI_EN),
        .IIR_EN(IIR_EN),
        .CTRL_EN(CTRL_EN),
        .CIC_EN(CIC_EN),
        .FIR_EN(FIR_EN),
        .PWRITE(PWRITE),
        .PENABLE(PENABLE),
        .DATA_ADDR(DATA_ADDR),
        .DATA_IN(DATA_IN),
        .PREADY(PREADY),
        .PRDATA(PRDATA)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=no_finish expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference address map, {FIR, CIC, CTRL, IIR, FRAC_DECI}; 0 = invalid.
    function automatic logic [4:0] refRegion(input logic [6:0] a);
        if (a < 7'd72)       return 5'b00001;
        else if (a < 7'd87)  return 5'b00010;
        else if (a == 7'd87) return 5'b01000;
        else if (a <= 7'd93) return 5'b00100;
        else if (a <= 7'd95) return 5'b00001;
        else if (a <= 7'd101) return 5'b00010;
        else if (a <= 7'd103) return 5'b01000;
        else if (a <= 7'd105) return 5'b10000;
        else return 5'b00000;
    endfunction

    function automatic logic [63:0] busView();
        return {18'd0, FIR_EN, CIC_EN, CTRL_EN, IIR_EN, FRAC_DECI_EN,
                PENABLE, PWRITE, DATA_ADDR, DATA_IN};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Issues one command at the current negedge and follows it to its
    // response. delay = number of ACCESS cycles before PREADY (>= TIMEOUT
    // means never); early additionally raises PREADY during SETUP.
    task automatic applyStimulus(input logic wr, input logic [6:0] addr,
                                 input logic [31:0] wdata, input int delay,
                                 input logic [31:0] rdata, input logic early);
        exp_t        e;
        exp_t        got;
        logic [4:0]  en;
        int          respCyc;
        int          k;
        logic        seen;
        en      = refRegion(addr);
        e.err   = (en == 5'b00000) || (delay >= TIMEOUT);
        e.rdata = (e.err || wr) ? 32'd0 : rdata;
        if (en == 5'b00000)      respCyc = 1;
        else if (delay >= TIMEOUT) respCyc = 2 + TIMEOUT;
        else                     respCyc = 3 + delay;

        checkOutput("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        PRDATA    = rdata;
        sb.push_back(e);
        if (e.err && errCnt < 255) errCnt++;

        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                cmd_valid = 1'b0;
                cmd_write = 1'($urandom);
                cmd_addr  = 7'($urandom);
                cmd_wdata = $urandom;
            end
            if (resp_valid) begin
                seen = 1'b1;
                checkOutput("resp_cycle", 64'(k), 64'(respCyc));
                checkOutput("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    got = sb.pop_front();
                    checkOutput("resp_err", 64'(resp_err), 64'(got.err));
                    checkOutput("resp_rdata", 64'(resp_rdata), 64'(got.rdata));
                end
                checkOutput("bus_idle_in_resp", busView(), 64'd0);
                checkOutput("err_count", 64'(err_count), 64'(errCnt));
            end else begin
                checkOutput("cmd_ready_busy", 64'(cmd_ready), 64'd0);
                if (k < respCyc)
                    checkOutput("bus_transfer", busView(),
                                {18'd0, en, (k > 1) ? 1'b1 : 1'b0, wr, addr, wdata});
            end
            PREADY = (k == 2 + delay) || (early && k == 1);
        end
        PREADY = 1'b0;
        checkOutput("resp_seen", 64'(seen), 64'd1);
        @(negedge clk);
        checkOutput("resp_pulse_end", 64'(resp_valid), 64'd0);
        checkOutput("cmd_ready_after", 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        PREADY    = 1'b0;
        PRDATA    = '0;

        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset_cmd_ready", 64'(cmd_ready), 64'd0);
        checkOutput("reset_bus", busView(), 64'd0);
        checkOutput("reset_resp", {23'd0, resp_valid, resp_err, resp_rdata, err_count}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("first_idle_ready", 64'(cmd_ready), 64'd1);

        $display("[TB] coefficient write, CIC read");
        applyStimulus(1'b1, 7'd5, 32'h0001_2345, 0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(1'b0, 7'd87, 32'h0, 0, 32'h0000_000A, 1'b0);

        $display("[TB] back-to-back CTRL and FIR writes");
        applyStimulus(1'b1, 7'd93, 32'h0000_0003, 1, 32'h0, 1'b0);
        applyStimulus(1'b1, 7'd104, 32'h0000_0001, 0, 32'h0, 1'b0);

        $display("[TB] invalid address and timeout");
        applyStimulus(1'b0, 7'd106, 32'h0, 0, 32'h1111_1111, 1'b0);
        applyStimulus(1'b1, 7'd72, 32'h0000_0777, 99, 32'h0, 1'b0);

        $display("[TB] region boundaries and late PREADY");
        applyStimulus(1'b0, 7'd86, 32'h0, TIMEOUT - 1, 32'h0000_5A5A, 1'b0);
        applyStimulus(1'b0, 7'd0, 32'h0, 2, 32'h1234_5678, 1'b1);
        applyStimulus(1'b0, 7'd95, 32'h0, 0, 32'h0000_0011, 1'b0);
        applyStimulus(1'b0, 7'd101, 32'h0, 1, 32'h0000_0022, 1'b0);
        applyStimulus(1'b1, 7'd103, 32'hFFFF_FFFF, 0, 32'h0, 1'b0);
        applyStimulus(1'b0, 7'd127, 32'h0, 0, 32'h0, 1'b0);

        $display("[TB] reset during ACCESS");
        checkOutput("cmd_ready_pre_rst", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 7'd80;
        cmd_wdata = 32'h0000_CAFE;
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("rst_setup_bus", busView(), {18'd0, 5'b00010, 1'b0, 1'b1, 7'd80, 32'h0000_CAFE});
        @(negedge clk);
        checkOutput("rst_access_penable", 64'(PENABLE), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_bus", busView(), 64'd0);
        checkOutput("rst_mid_resp", {22'd0, cmd_ready, resp_valid, resp_err, resp_rdata, err_count}, 64'd0);
        rst    = 1'b0;
        errCnt = 0;
        @(negedge clk);
        checkOutput("rst_release_ready", 64'(cmd_ready), 64'd1);
        checkOutput("rst_release_resp", 64'(resp_valid), 64'd0);
        checkOutput("rst_release_errcnt", 64'(err_count), 64'd0);

        applyStimulus(1'b0, 7'd105, 32'h0, 0, 32'h0000_00C3, 1'b0);
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
